// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax sequencer: Q4.12 widths, FSM encoding
// and the signed running-max function.
package softmax_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 12;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Strict greater-than, so on a tie the earlier value (a) is kept.
  function automatic logic [Q_W-1:0] q412_max(input logic [Q_W-1:0] a,
                                             input logic [Q_W-1:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

endpackage

// File: rtl/softmax_max_tracker.sv
// Running signed maximum of a Q4.12 stream with clear, load and update controls.
module softmax_max_tracker
  import softmax_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           load,
  input  logic           upd,
  input  logic [Q_W-1:0] d,
  output logic [Q_W-1:0] max_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       max_q <= '0;
    else if (clr)   max_q <= '0;
    else if (load)  max_q <= d;
    else if (upd)   max_q <= q412_max(max_q, d);
  end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer for the N-lane Q4.12 softmax datapath: load N elements, run the datapath,
// stream out the probabilities. Define SOFTMAX_CTRL_PERF_EN to add perf_vec/perf_stall.
//
// state | meaning
// LOAD  | accepting elements into the lane buffer, tracking the running max
// RUN   | datapath enabled for DP_LAT cycles, then one capture cycle with dp_en low
// DRAIN | presenting captured probabilities one per handshake
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int N      = 4,
  parameter int DP_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_data,
  output logic             out_last,
  output logic [Q_W*N-1:0] dp_in_x_flat,
  output logic [Q_W-1:0]   dp_max_x,
  output logic             dp_en,
  input  logic [Q_W*N-1:0] dp_prob_flat,
  output logic             busy
`ifdef SOFTMAX_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_vec,
  output logic [31:0]      perf_stall
`endif
);

  localparam int CW = $clog2(N);
  localparam int TW = $clog2(DP_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [TW-1:0] LAT  = TW'(DP_LAT);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, idx, idx_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [Q_W-1:0]  xbuf [N];
  logic [Q_W-1:0]  pbuf [N];
  logic [Q_W-1:0]  out_data_nxt;
  logic            beat, xfer, last_xfer, capture;
  logic            dp_en_nxt, out_valid_nxt, out_last_nxt, in_ready_nxt, busy_nxt;

  // in_ready is only ever high in LOAD and out_valid only in DRAIN.
  assign beat      = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer && (idx == LAST);
  assign capture   = (state == RUN) && (tmr == '0);

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign dp_in_x_flat[k*Q_W +: Q_W] = xbuf[k];
  end

  softmax_max_tracker u_max (
    .clk   (clk),
    .rst   (rst),
    .clr   (last_xfer),
    .load  (beat && (cnt == '0)),
    .upd   (beat && (cnt != '0)),
    .d     (in_data),
    .max_q (dp_max_x)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    tmr_nxt       = tmr;
    dp_en_nxt     = dp_en;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    out_data_nxt  = out_data;
    case (state)
      LOAD: begin
        if (beat) begin
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
            tmr_nxt   = LAT;
            dp_en_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      RUN: begin
        if (tmr != '0) begin
          tmr_nxt   = tmr - TW'(1);
          dp_en_nxt = (tmr != TW'(1));
        end else begin
          state_nxt     = DRAIN;
          dp_en_nxt     = 1'b0;
          out_valid_nxt = 1'b1;
          idx_nxt       = '0;
          out_data_nxt  = dp_prob_flat[Q_W-1:0];
          out_last_nxt  = 1'b0;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_nxt     = LOAD;
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
        end else if (xfer) begin
          idx_nxt      = idx + CW'(1);
          out_data_nxt = pbuf[idx_nxt];
          out_last_nxt = (idx_nxt == LAST);
        end
      end
      default: state_nxt = LOAD;
    endcase
    in_ready_nxt = (state_nxt == LOAD);
    busy_nxt     = !((state_nxt == LOAD) && (cnt_nxt == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      idx       <= '0;
      tmr       <= '0;
      dp_en     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        xbuf[k] <= '0;
        pbuf[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      tmr       <= tmr_nxt;
      dp_en     <= dp_en_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      out_data  <= out_data_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      if (beat) xbuf[cnt] <= in_data;
      if (capture) begin
        for (int k = 0; k < N; k++) pbuf[k] <= dp_prob_flat[k*Q_W +: Q_W];
      end
    end
  end

`ifdef SOFTMAX_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_vec   <= '0;
      perf_stall <= '0;
    end else begin
      if (last_xfer) perf_vec <= perf_vec + 32'd1;
      if ((state == DRAIN) && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed self-checking bench for softmax_seq_ctrl with a latency-aware stub datapath.
`timescale 1ns/1ps
module tb_softmax_seq_ctrl;

  localparam int N      = 4;
  localparam int DP_LAT = 8;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, dp_en, busy;
  logic [15:0] in_data, out_data, dp_max_x;
  logic [63:0] dp_in_x_flat, dp_prob_flat, stub_val;
  int          en_cnt = 0;
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          exp_vec = 0, exp_stall = 0;
  bit          hold = 1'b0;
`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0] perf_vec, perf_stall;
`endif

  always #5 clk = ~clk;

  softmax_seq_ctrl #(.N(N), .DP_LAT(DP_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .dp_in_x_flat (dp_in_x_flat),
    .dp_max_x     (dp_max_x),
    .dp_en        (dp_en),
    .dp_prob_flat (dp_prob_flat),
    .busy         (busy)
`ifdef SOFTMAX_CTRL_PERF_EN
    ,
    .perf_vec     (perf_vec),
    .perf_stall   (perf_stall)
`endif
  );

  // Stub datapath: probabilities only become valid once dp_en has been held DP_LAT cycles.
  always @(posedge clk) begin
    if (in_ready)   en_cnt <= 0;
    else if (dp_en) en_cnt <= en_cnt + 1;
  end
  assign dp_prob_flat = (en_cnt >= DP_LAT) ? stub_val : {4{16'hDEAD}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf();
`ifdef SOFTMAX_CTRL_PERF_EN
    chk("perf_vec", perf_vec, exp_vec);
    chk("perf_stall", perf_stall, exp_stall);
`endif
  endtask

  task automatic check_reset();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_dp_en", dp_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_max", dp_max_x, 16'h0);
    chk("rst_flat", dp_in_x_flat, 64'h0);
    chk("rst_out_data", out_data, 16'h0);
  endtask

  task automatic send_vec(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic [15:0] exp_max);
    logic [15:0] v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      @(negedge clk);
      if (i == 0) begin
        chk("load_busy", busy, 1'b1);
        chk("load_in_ready", in_ready, 1'b1);
      end
    end
    in_valid = hold;
    in_data  = 16'h7777;
    chk("run_max", dp_max_x, exp_max);
    chk("run_flat", dp_in_x_flat, {d, c, b, a});
    chk("run_in_ready", in_ready, 1'b0);
    chk("run_dp_en", dp_en, 1'b1);
    chk("run_busy", busy, 1'b1);
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      if (hold) chk("hold_in_ready_run", in_ready, 1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, DP_LAT + 1);
    chk("dp_en_cycles", en_cnt, DP_LAT);
    chk("dp_en_low", dp_en, 1'b0);
  endtask

  task automatic drain(input logic [63:0] probs, input bit toggle);
    int  k, cyc, stalls;
    bit  rdy;
    k = 0; cyc = 0; stalls = 0;
    while (k < 4 && cyc < 40) begin
      rdy = !toggle || (cyc % 2 == 0);
      out_ready = rdy;
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_data", out_data, probs[16*k +: 16]);
      chk("drain_last", out_last, (k == 3));
      if (hold) chk("hold_in_ready_drain", in_ready, 1'b0);
      if (rdy && k == 3) in_valid = 1'b0;
      if (rdy) k++;
      else stalls++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_count", k, 4);
    chk("drain_done_valid", out_valid, 1'b0);
    chk("drain_done_in_ready", in_ready, 1'b1);
    chk("drain_done_busy", busy, 1'b0);
    exp_vec++;
    exp_stall += stalls;
    chk_perf();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    stub_val = 64'h0C00_0800_0400_0200;
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    @(negedge clk);

    // mixed-sign vector, full-rate drain
    send_vec(16'hEC80, 16'hFE18, 16'h2771, 16'h15DB, 16'h2771);
    wait_out();
    drain(stub_val, 1'b0);

    // all-negative, including the most-negative code; stalled drain
    stub_val = 64'h4444_3333_2222_1111;
    send_vec(16'h8000, 16'hF000, 16'hFFFF, 16'hC000, 16'hFFFF);
    wait_out();
    drain(stub_val, 1'b1);

    // all-equal inputs
    stub_val = 64'h0400_0400_0400_0400;
    send_vec(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
    wait_out();
    drain(stub_val, 1'b0);

    // reset three cycles into RUN
    stub_val = 64'h0FFF_0AAA_0555_0001;
    send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0400);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset();
    exp_vec = 0;
    exp_stall = 0;
    chk_perf();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_vec(16'h1000, 16'h2000, 16'h3000, 16'h0800, 16'h3000);
    wait_out();
    drain(stub_val, 1'b0);

    // in_valid held high through RUN and DRAIN, then back-to-back vector
    hold = 1'b1;
    stub_val = 64'h0123_4567_89AB_CDEF;
    send_vec(16'h0123, 16'h0456, 16'hF789, 16'h0ABC, 16'h0ABC);
    wait_out();
    drain(stub_val, 1'b1);
    hold = 1'b0;
    chk("hold_flat_kept", dp_in_x_flat, 64'h0ABC_F789_0456_0123);
    stub_val = 64'h7000_0100_0020_0003;
    send_vec(16'h7FFF, 16'h8000, 16'h0001, 16'h7FFE, 16'h7FFF);
    wait_out();
    drain(stub_val, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
